// File: rtl/vend_order_issuer.sv
// vend_order_issuer: buffers vending orders, issues them one at a time to the seller and reports each result
module vend_order_issuer #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 16,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             order_valid_i,
    input  logic [5:0]       order_money_i,
    input  logic [1:0]       order_type_i,
    output logic             order_ready_o,
    input  logic             seller_ready_i,
    output logic             seller_enable_o,
    output logic [5:0]       seller_money_o,
    output logic [1:0]       seller_type_o,
    input  logic             seller_done_i,
    input  logic [5:0]       seller_change_i,
    input  logic [1:0]       seller_drink_i,
    output logic             result_valid_o,
    output logic [5:0]       result_change_o,
    output logic [1:0]       result_drink_o,
    output logic             result_ok_o,
    output logic             result_timeout_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] sold_cnt_o,
    output logic [CNT_W-1:0] timeout_cnt_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, WAIT_DONE, REPORT} state_t;

    state_t           r_state, w_state_nxt;
    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
    logic [AW:0]      r_count;
    logic [TW-1:0]    r_timer;
    logic             r_enable, r_ok, r_timeout;
    logic [5:0]       r_money, r_change;
    logic [1:0]       r_type, r_drink;
    logic [CNT_W-1:0] r_sold, r_tocnt;
    logic             w_full, w_push, w_pop, w_done, w_expire;

    assign w_full = r_count == (AW+1)'(FIFO_DEPTH);
    assign w_push = order_valid_i && !w_full;

    // Handshake decode and next state; a done pulse wins over the timer expiring in the same cycle
    always_comb begin
        w_pop       = r_state == IDLE && r_count != '0 && seller_ready_i;
        w_done      = r_state == WAIT_DONE && seller_done_i;
        w_expire    = r_state == WAIT_DONE && !seller_done_i && r_timer == TW'(TIMEOUT - 1);
        w_state_nxt = r_state;
        w_state_nxt = w_pop ? WAIT_DONE : (w_done || w_expire) ? REPORT : (r_state == REPORT) ? IDLE : r_state;
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Order storage; contents need no reset because occupancy gates every read
    always_ff @(posedge clk) begin
        if (reset && w_push) r_mem[r_wr_ptr] <= {order_money_i, order_type_i};
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    // Issue registers: enable pulses for the first WAIT_DONE cycle, order fields held until the next issue
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_enable <= 1'b0;
            r_money  <= '0;
            r_type   <= '0;
            r_timer  <= '0;
        end else begin
            r_enable <= w_pop;
            if (w_pop) {r_money, r_type} <= r_mem[r_rd_ptr];
            r_timer <= w_pop ? '0 : (r_state == WAIT_DONE) ? r_timer + TW'(1) : r_timer;
        end
    end

    // Result capture on completion or abandonment; fields hold until the next report
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_change  <= '0;
            r_drink   <= '0;
            r_ok      <= 1'b0;
            r_timeout <= 1'b0;
        end else if (w_done) begin
            r_change  <= seller_change_i;
            r_drink   <= seller_drink_i;
            r_ok      <= seller_drink_i == r_type && seller_drink_i != 2'd0;
            r_timeout <= 1'b0;
        end else if (w_expire) begin
            r_change  <= r_money;
            r_drink   <= 2'd0;
            r_ok      <= 1'b0;
            r_timeout <= 1'b1;
        end
    end

    // Saturating statistics, updated as each result is reported
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sold  <= '0;
            r_tocnt <= '0;
        end else if (r_state == REPORT) begin
            if (r_ok && r_sold != '1)       r_sold  <= r_sold + CNT_W'(1);
            if (r_timeout && r_tocnt != '1) r_tocnt <= r_tocnt + CNT_W'(1);
        end
    end

    assign order_ready_o    = !w_full;
    assign seller_enable_o  = r_enable;
    assign seller_money_o   = r_money;
    assign seller_type_o    = r_type;
    assign result_valid_o   = r_state == REPORT;
    assign result_change_o  = r_change;
    assign result_drink_o   = r_drink;
    assign result_ok_o      = r_ok;
    assign result_timeout_o = r_timeout;
    assign busy_o           = r_state != IDLE;
    assign sold_cnt_o       = r_sold;
    assign timeout_cnt_o    = r_tocnt;
endmodule

// File: tb/tb_vend_order_issuer.sv
// tb_vend_order_issuer: randomized and directed checks of the order issuer against a behavioural model
module tb_vend_order_issuer;
    localparam int DEPTH = 4;
    localparam int T     = 16;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0, reset = 1'b0;
    logic          order_valid_i = 1'b0, seller_ready_i = 1'b0, seller_done_i = 1'b0;
    logic [5:0]    order_money_i = '0, seller_change_i = '0;
    logic [1:0]    order_type_i = '0, seller_drink_i = '0;
    logic          order_ready_o, seller_enable_o, result_valid_o, result_ok_o, result_timeout_o, busy_o;
    logic [5:0]    seller_money_o, result_change_o;
    logic [1:0]    seller_type_o, result_drink_o;
    logic [CW-1:0] sold_cnt_o, timeout_cnt_o;

    vend_order_issuer #(.FIFO_DEPTH(DEPTH), .TIMEOUT(T), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .order_valid_i(order_valid_i), .order_money_i(order_money_i), .order_type_i(order_type_i),
        .order_ready_o(order_ready_o), .seller_ready_i(seller_ready_i), .seller_enable_o(seller_enable_o),
        .seller_money_o(seller_money_o), .seller_type_o(seller_type_o), .seller_done_i(seller_done_i),
        .seller_change_i(seller_change_i), .seller_drink_i(seller_drink_i),
        .result_valid_o(result_valid_o), .result_change_o(result_change_o), .result_drink_o(result_drink_o),
        .result_ok_o(result_ok_o), .result_timeout_o(result_timeout_o), .busy_o(busy_o),
        .sold_cnt_o(sold_cnt_o), .timeout_cnt_o(timeout_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic [5:0] m; logic [1:0] t;} ord_t;

    ord_t       q[$];
    int         n_chk = 0, n_fail = 0;
    bit         rnd = 1'b0;
    int         dmode = 1;
    bit         infl = 1'b0;
    int         k = 0, d = 0, roff = 0;
    logic [5:0] m_money = '0, m_chg = '0, p_chg = '0, s_chg = '0;
    logic [1:0] m_type = '0, m_drk = '0, p_drk = '0, s_drk = '0;
    bit         m_ok = 1'b0, m_to = 1'b0, p_ok = 1'b0, p_to = 1'b0;
    int         m_sold = 0, m_tocnt = 0;
    int         n;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Bench seller: drinks cost 30/20/15; short money or type 0 returns everything
    task automatic seller_resp(input logic [5:0] m, input logic [1:0] t, output logic [5:0] c, output logic [1:0] dr);
        int cost;
        cost = (t == 2'd1) ? 30 : (t == 2'd2) ? 20 : 15;
        if (t != 2'd0 && int'(m) >= cost) begin
            c  = 6'(int'(m) - cost);
            dr = t;
        end else begin
            c  = m;
            dr = 2'd0;
        end
    endtask

    // One clock: drive seller, advance the model across the edge, then compare at the next negedge
    task automatic step();
        bit   pop, push;
        ord_t o;
        if (rnd) begin
            order_valid_i  = ($urandom % 3) == 0;
            order_money_i  = 6'($urandom);
            order_type_i   = 2'($urandom);
            seller_ready_i = ($urandom % 4) != 0;
        end
        if (infl && k == d) begin
            seller_done_i   = 1'b1;
            seller_change_i = s_chg;
            seller_drink_i  = s_drk;
        end else begin
            seller_done_i   = rnd && (!infl || k == roff) && ($urandom % 8) == 0;
            seller_change_i = 6'($urandom);
            seller_drink_i  = 2'($urandom);
        end
        if (!reset) begin
            q.delete();
            infl = 0; k = 0;
            m_money = '0; m_type = '0; m_chg = '0; m_drk = '0; m_ok = 0; m_to = 0;
            m_sold = 0; m_tocnt = 0;
        end else begin
            pop  = !infl && q.size() > 0 && seller_ready_i;
            push = order_valid_i && q.size() < DEPTH;
            if (infl) begin
                if (k == roff) begin
                    infl = 0;
                    if (m_ok && m_sold < CMAX) m_sold++;
                    if (m_to && m_tocnt < CMAX) m_tocnt++;
                end else begin
                    k++;
                    if (k == roff) begin
                        m_chg = p_chg; m_drk = p_drk; m_ok = p_ok; m_to = p_to;
                    end
                end
            end
            if (pop) begin
                o = q.pop_front();
                m_money = o.m; m_type = o.t;
                infl = 1; k = 0;
                d = dmode >= 0 ? dmode : ($urandom % 8 == 0) ? 1000 : ($urandom % 7 == 0) ? int'($urandom_range(0, T + 1)) : int'($urandom_range(0, 3));
                seller_resp(o.m, o.t, s_chg, s_drk);
                if (rnd && $urandom % 8 == 0) s_drk = 2'($urandom);
                if (d <= T - 1) begin
                    roff = d + 1;
                    p_chg = s_chg; p_drk = s_drk; p_ok = s_drk == o.t && s_drk != 2'd0; p_to = 0;
                end else begin
                    roff = T;
                    p_chg = o.m; p_drk = 2'd0; p_ok = 0; p_to = 1;
                end
            end
            if (push) q.push_back({order_money_i, order_type_i});
        end
        @(negedge clk);
        chk("order_ready", order_ready_o, q.size() < DEPTH);
        chk("busy", busy_o, infl);
        chk("seller_enable", seller_enable_o, infl && k == 0);
        chk("seller_money", seller_money_o, m_money);
        chk("seller_type", seller_type_o, m_type);
        chk("result_valid", result_valid_o, infl && k == roff);
        chk("result_change", result_change_o, m_chg);
        chk("result_drink", result_drink_o, m_drk);
        chk("result_ok", result_ok_o, m_ok);
        chk("result_timeout", result_timeout_o, m_to);
        chk("sold_cnt", sold_cnt_o, m_sold);
        chk("timeout_cnt", timeout_cnt_o, m_tocnt);
    endtask

    task automatic push1(input logic [5:0] m, input logic [1:0] t);
        order_valid_i = 1'b1; order_money_i = m; order_type_i = t;
        step();
        order_valid_i = 1'b0;
    endtask

    task automatic wait_enable(input int maxn);
        int i = 0;
        do begin step(); i++; end while (seller_enable_o !== 1'b1 && i < maxn);
        chk("wait_enable", seller_enable_o, 1);
    endtask

    task automatic wait_result(input int maxn, output int cnt);
        cnt = 0;
        do begin step(); cnt++; end while (result_valid_o !== 1'b1 && cnt < maxn);
        chk("wait_result", result_valid_o, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        step();
        chk("rst_ready", order_ready_o, 1);
        chk("rst_busy", busy_o, 0);
        reset = 1'b1;
        seller_ready_i = 1'b1;
        dmode = 1;
        push1(6'd40, 2'd1);
        wait_enable(10);
        chk("single_money", seller_money_o, 40);
        chk("single_type", seller_type_o, 1);
        wait_result(10, n);
        chk("single_latency", n, 2);
        chk("single_change", result_change_o, 10);
        chk("single_drink", result_drink_o, 1);
        chk("single_ok", result_ok_o, 1);
        step();
        chk("single_sold", sold_cnt_o, 1);
        push1(6'd10, 2'd3);
        wait_result(20, n);
        chk("short_change", result_change_o, 10);
        chk("short_drink", result_drink_o, 0);
        chk("short_ok", result_ok_o, 0);
        chk("short_timeout", result_timeout_o, 0);
        step();
        chk("short_sold", sold_cnt_o, 1);
        push1(6'd30, 2'd0);
        wait_result(20, n);
        chk("type0_ok", result_ok_o, 0);
        chk("type0_change", result_change_o, 30);
        dmode = 1000;
        push1(6'd50, 2'd1);
        wait_enable(10);
        wait_result(40, n);
        chk("to_latency", n, 16);
        chk("to_flag", result_timeout_o, 1);
        chk("to_change", result_change_o, 50);
        chk("to_drink", result_drink_o, 0);
        step();
        chk("to_cnt", timeout_cnt_o, 1);
        dmode = 1;
        push1(6'd20, 2'd3);
        wait_enable(10);
        wait_result(10, n);
        chk("after_to_change", result_change_o, 5);
        chk("after_to_ok", result_ok_o, 1);
        dmode = T - 1;
        push1(6'd45, 2'd2);
        wait_enable(10);
        wait_result(40, n);
        chk("edge_latency", n, 16);
        chk("edge_timeout", result_timeout_o, 0);
        chk("edge_change", result_change_o, 25);
        dmode = T;
        push1(6'd45, 2'd2);
        wait_enable(10);
        wait_result(40, n);
        chk("late_timeout", result_timeout_o, 1);
        chk("late_change", result_change_o, 45);
        dmode = 1;
        repeat (3) step();
        seller_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) push1(6'(35 + i), 2'd2);
        chk("bp_full", order_ready_o, 0);
        seller_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_result(20, n);
            chk("bp_order", result_change_o, 15 + i);
        end
        repeat (4) step();
        chk("bp_drained", busy_o, 0);
        seller_ready_i = 1'b0;
        push1(6'd63, 2'd1);
        push1(6'd62, 2'd1);
        seller_ready_i = 1'b1;
        push1(6'd61, 2'd1);
        seller_ready_i = 1'b0;
        push1(6'd60, 2'd1);
        chk("pp_ready_occ3", order_ready_o, 1);
        push1(6'd59, 2'd1);
        chk("pp_ready_occ4", order_ready_o, 0);
        seller_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) wait_result(20, n);
        dmode = 1000;
        push1(6'd33, 2'd1);
        wait_enable(10);
        step();
        reset = 1'b0;
        step();
        chk("rst_mid_valid", result_valid_o, 0);
        chk("rst_mid_enable", seller_enable_o, 0);
        chk("rst_mid_busy", busy_o, 0);
        chk("rst_mid_ready", order_ready_o, 1);
        chk("rst_mid_sold", sold_cnt_o, 0);
        reset = 1'b1;
        repeat (8) step();
        chk("rst_no_issue", busy_o, 0);
        rnd = 1'b1;
        dmode = -1;
        repeat (3000) step();
        rnd = 1'b0;
        order_valid_i = 1'b0;
        seller_ready_i = 1'b1;
        repeat (300) step();
        dmode = 1;
        for (int i = 0; i < 17; i++) begin
            push1(6'd63, 2'd3);
            wait_result(20, n);
        end
        step();
        chk("sold_saturate", sold_cnt_o, CMAX);
        dmode = 1000;
        for (int i = 0; i < 16; i++) begin
            push1(6'd1, 2'd1);
            wait_result(40, n);
        end
        step();
        chk("to_saturate", timeout_cnt_o, CMAX);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/vend_order_issuer.md
Name: vend_order_issuer

Overview:
- Customer-side initiator for the vending-machine seller interface.
- Buffers purchase orders (money, drink type) in a small FIFO.
- Issues each order to the seller as a one-cycle enable pulse when the seller is ready, then waits for the seller's completion pulse, capturing change and dispensed drink.
- Reports one result per order, with timeout protection and running statistics.
- Sits between the host/test stimulus logic and the seller block.

Parameters:
- FIFO_DEPTH, 4, order buffer entries; power of 2, ≥2.
- TIMEOUT, 16, cycles spent in WAIT_DONE before an order is abandoned; ≥2.
- CNT_W, 8, width of the statistics counters.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- order_valid_i  input  1  host offers an order.
- order_money_i  input  6  inserted money for the order.
- order_type_i  input  2  requested drink; 0 = none, 1..3 = drink.
- order_ready_o  output  1  FIFO not full; push occurs when valid and ready are both high.
- seller_ready_i  input  1  seller idle and able to accept.
- seller_enable_o  output  1  one-cycle request pulse to the seller.
- seller_money_o  output  6  money for the issued order.
- seller_type_o  output  2  drink type for the issued order.
- seller_done_i  input  1  seller completion pulse.
- seller_change_i  input  6  change, valid when seller_done_i is high.
- seller_drink_i  input  2  dispensed drink, valid when seller_done_i is high.
- result_valid_o  output  1  one-cycle result pulse.
- result_change_o  output  6  captured change; equals the order money on timeout.
- result_drink_o  output  2  captured drink; 0 on timeout.
- result_ok_o  output  1  dispensed drink equals requested drink, and is nonzero.
- result_timeout_o  output  1  order abandoned due to timeout.
- busy_o  output  1  state is not IDLE.
- sold_cnt_o  output  CNT_W  count of results with result_ok_o high; saturating.
- timeout_cnt_o  output  CNT_W  count of timeouts; saturating.

Behaviour:
- Reset (reset low at a clock edge):
  - FIFO emptied; state goes to IDLE.
  - All outputs 0, except order_ready_o, which is 1.
  - Reset mid-transaction drops the in-flight order with no result pulse and deasserts seller_enable_o on the next cycle.
- FIFO:
  - Push when order_valid_i and order_ready_o are both high.
  - order_ready_o = not full, combinational from occupancy. A push while full is ignored even if a pop happens in the same cycle.
  - A simultaneous push and pop on a non-full, non-empty FIFO keeps occupancy unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- States: IDLE, WAIT_DONE, REPORT.
  - IDLE: if the FIFO is non-empty and seller_ready_i is high, pop the head and register seller_money_o/seller_type_o from it. Set seller_enable_o to 1, clear the timer, go to WAIT_DONE. Otherwise stay in IDLE.
  - WAIT_DONE:
    - seller_enable_o is high only in the first WAIT_DONE cycle. seller_money_o/seller_type_o are held until the next issue.
    - Timer increments each cycle.
    - If seller_done_i is high: capture change and drink, set ok = (drink == seller_type_o) and (drink != 0), set timeout = 0, go to REPORT.
    - Else if the timer reaches TIMEOUT-1: set change = seller_money_o, drink = 0, ok = 0, timeout = 1, go to REPORT.
    - seller_done_i takes priority over timeout in the same cycle.
    - seller_done_i is ignored outside WAIT_DONE.
  - REPORT: result_valid_o high for exactly this one cycle, with the registered result fields. Update counters. Go to IDLE.
- Result fields hold their values until the next REPORT.
- Minimum order-to-order spacing: 3 cycles (IDLE, WAIT_DONE, REPORT).
- Latency from issue to result: (cycles until done) + 1.
- Counters saturate at 2^CNT_W − 1 and never wrap.
- Order type 0 is issued normally; its result_ok_o is always 0.

Test Plan:
- Bench seller model: cost 30/20/15 for types 1/2/3; completion 1 cycle after the enable pulse.
- Single order money=40, type=1, seller ready → seller_enable_o pulses once with money 40, type 1; result_valid_o pulses with change=10, drink=1, ok=1; sold_cnt_o=1.
- Insufficient funds: money=10, type=3 → seller returns change=10, drink=0 → result ok=0, timeout=0; sold_cnt_o unchanged.
- Back-pressure: push 5 orders with FIFO_DEPTH=4 while seller_ready_i=0 → order_ready_o falls after the 4th push and the 5th is not accepted. Raise ready → exactly 4 results, in push order.
- Timeout: seller never asserts done, TIMEOUT=16 → result_timeout_o=1, change equals order money, drink=0, timeout_cnt_o=1; next order proceeds normally.
- Reset low during WAIT_DONE → no result pulse; all outputs 0, order_ready_o=1; FIFO empty, so no further seller_enable_o after reset releases.
- Edge cases:
  - seller_done_i on the exact TIMEOUT-1 cycle → success result with timeout=0.
  - Simultaneous push and pop at occupancy 2 → occupancy stays 2.
